// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divide/remainder controller (DIV, DIVU, REM, REMU).
// A restoring divider runs one quotient bit per clock for 32 iterations. The RISC-V
// divide-by-zero and signed-overflow results are produced early, without iterating.
//
// Ports:
//   CLK       sole clock, rising edge
//   RESET     asynchronous active-low reset
//   START     request valid, sampled only while idle
//   FUNCT3    100 DIV, 101 DIVU, 110 REM, 111 REMU (bit 2 low: request ignored)
//   OPERAND1  dividend (rs1), captured on the accept edge
//   OPERAND2  divisor (rs2), captured on the accept edge
//   FLUSH     synchronous abort of the current or requested operation
//   BUSY      high while an operation is in flight
//   DONE      one-cycle pulse marking RESULT valid
//   RESULT    quotient or remainder, held until the next DONE
module div_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] OPERAND1,
  input  logic [31:0] OPERAND2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state;
  logic [5:0]          cnt;
  logic [DATA_W:0]     r;          // partial remainder, one guard bit for the compare
  logic [DATA_W-1:0]   q;          // shifts the dividend out and the quotient in
  logic [DATA_W-1:0]   dvs;        // divisor magnitude
  logic [DATA_W-1:0]   spec_res;   // precomputed special-case result
  logic                op_signed;
  logic                op_rem;
  logic                dvd_sign;
  logic                quo_sign;
  logic                special;

  function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] x);
    return ~x + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a signed operand; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x,
                                            input logic sgn);
    return (sgn && x < 0) ? neg2c(x) : x;
  endfunction

  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;
  logic                     acc_signed;
  logic                     acc_rem;
  logic                     div_zero;
  logic                     ovf;
  logic [DATA_W-1:0]        acc_spec;
  logic [DATA_W:0]          t;
  logic [DATA_W:0]          diff;
  logic                     ge;
  logic [DATA_W-1:0]        fix_raw;
  logic                     fix_neg;
  logic [DATA_W-1:0]        fix_res;

  always_comb begin
    op1_s      = OPERAND1;
    op2_s      = OPERAND2;
    acc_signed = ~FUNCT3[0];
    acc_rem    = FUNCT3[1];
    div_zero   = (OPERAND2 == '0);
    ovf        = acc_signed && (OPERAND1 == 32'h8000_0000) && (OPERAND2 == 32'hFFFF_FFFF);
    if (div_zero)
      acc_spec = acc_rem ? OPERAND1 : 32'hFFFF_FFFF;
    else
      acc_spec = acc_rem ? 32'h0000_0000 : 32'h8000_0000;

    // One restoring step: shift the next dividend bit into the remainder, try to subtract.
    t    = {r[DATA_W-1:0], q[DATA_W-1]};
    diff = t - {1'b0, dvs};
    ge   = (t >= {1'b0, dvs});

    // Quotient takes the XOR of the operand signs; remainder follows the dividend.
    fix_raw = op_rem ? r[DATA_W-1:0] : q;
    fix_neg = op_signed && (op_rem ? dvd_sign : quo_sign);
    fix_res = special ? spec_res : (fix_neg ? neg2c(fix_raw) : fix_raw);
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      spec_res  <= '0;
      op_signed <= 1'b0;
      op_rem    <= 1'b0;
      dvd_sign  <= 1'b0;
      quo_sign  <= 1'b0;
      special   <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= '0;
    end else begin
      DONE <= 1'b0;
      // FLUSH wins over everything, including a FIX exit and a new START.
      if (FLUSH) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (START && FUNCT3[2]) begin
              op_signed <= acc_signed;
              op_rem    <= acc_rem;
              dvd_sign  <= acc_signed & OPERAND1[DATA_W-1];
              quo_sign  <= acc_signed & (OPERAND1[DATA_W-1] ^ OPERAND2[DATA_W-1]);
              q         <= mag(op1_s, acc_signed);
              dvs       <= mag(op2_s, acc_signed);
              cnt       <= '0;
              r         <= '0;
              special   <= div_zero | ovf;
              spec_res  <= acc_spec;
              state     <= (div_zero | ovf) ? FIX : CALC;
            end
          end
          CALC: begin
            r   <= ge ? diff : t;
            q   <= {q[DATA_W-2:0], ge};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31)
              state <= FIX;
          end
          FIX: begin
            RESULT <= fix_res;
            DONE   <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU) in the execute stage. It accepts one request per handshake, runs a 32-iteration restoring divider, applies the RISC-V sign and special-case rules, and returns a registered result with a one-cycle DONE pulse. BUSY holds the pipeline stall logic while an operation is in flight. FLUSH lets branch/jump resolution abort an in-flight operation.

## Interface
- No parameters. Data width is fixed at 32.
- CLK  input  1  sole clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request valid; sampled only in IDLE.
- FUNCT3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU. FUNCT3[2]=0 means START is ignored.
- OPERAND1  input  32  dividend (rs1), sampled on the accept edge.
- OPERAND2  input  32  divisor (rs2), sampled on the accept edge.
- FLUSH  input  1  synchronous abort of the current or requested operation.
- BUSY  output  1  high whenever state ≠ IDLE.
- DONE  output  1  registered pulse, high for exactly one cycle when RESULT is valid.
- RESULT  output  32  registered quotient or remainder; holds its value until the next DONE.

## Operation
- States: IDLE, CALC, FIX.
- **Accept:** occurs in IDLE when START=1, FUNCT3[2]=1 and FLUSH=0. On the accept edge the block latches:
  - op, signed flag (FUNCT3[0]=0), and rem flag (FUNCT3[1]).
  - sign of dividend, and quotient sign (sign of dividend XOR sign of divisor, signed ops only).
  - |OPERAND1| and |OPERAND2| for signed ops, raw values for unsigned ops.
  - Clears the 6-bit iteration counter and the 33-bit partial remainder R.
- **Special cases** are detected on the accept edge and go straight to FIX with a precomputed result:
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give OPERAND1.
  - Signed overflow (OPERAND1=0x80000000, OPERAND2=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000, REM gives 0.
- **Normal case:** accept goes to CALC.
- **CALC**, one iteration per edge:
  - T = {R[31:0], Q[31]} (33 bits).
  - If T ≥ {1'b0, divisor}: R = T − divisor and Q = {Q[30:0], 1}. Otherwise R = T and Q = {Q[30:0], 0}.
  - Q starts as the magnitude dividend.
  - Counter increments each edge; after the 32nd iteration (counter = 31 on that edge) the state goes to FIX.
- **FIX** (one edge):
  - Result is Q (DIV/DIVU) or R[31:0] (REM/REMU).
  - For signed ops, negate a quotient when the quotient sign is 1, and negate a remainder when the dividend sign is 1.
  - Write RESULT, set DONE=1, go to IDLE.
- DONE is cleared on every edge where FIX is not being exited.
- **FLUSH=1**, in any state, on the next edge:
  - State becomes IDLE and no DONE is produced. FLUSH cancels a DONE pending from FIX on the same edge.
  - RESULT is unchanged.
  - FLUSH beats a simultaneous START.
- START while BUSY is ignored; the request is not queued.
- Reset mid-operation: everything returns immediately to reset values, and no DONE follows.

## Timing
- **Reset values:** BUSY=0, DONE=0, RESULT=0x00000000, state IDLE, counter 0, R=0, Q=0.
- **Normal latency:** accept edge E0, iterations on E1–E32, FIX exit on E33. DONE and RESULT are valid in the cycle after E33, which is 33 edges after accept.
- **Special-case latency:** DONE is valid in the cycle after E1, one edge after accept.
- BUSY is high from the cycle after E0 through the cycle before DONE. It is low in the DONE cycle.
- **Back-to-back:** a new START can be accepted in the DONE cycle, giving a 34-cycle normal issue interval.
- **Arithmetic widths:** the compare and subtract are 33-bit unsigned. Negation is 32-bit two's complement. Magnitude of 0x80000000 is 0x80000000 read as unsigned.

## Test plan
- DIV 100 / 7 → BUSY high for 33 cycles, then DONE for one cycle with RESULT=14. The same operands with REM → 2.
- Signed mixes:
  - DIV −100 / 7 → 0xFFFFFFF2 (−14).
  - REM −100 / 7 → 0xFFFFFFFE (−2).
  - REM 100 / −7 → 2.
  - DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- Divide by zero, one-cycle latency:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 0x12345678 / 0 → 0x12345678.
- Overflow, one-cycle latency:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- FLUSH asserted on the 10th CALC cycle → BUSY low next cycle, no DONE, RESULT keeps its previous value. A START held during that FLUSH is not accepted.
- RESET asserted mid-CALC → outputs go to zero immediately. A START while BUSY is ignored. A START in the DONE cycle is accepted, with the next DONE 33 edges later.
